mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
Arbitrates a single shared, fixed-latency memory port between the fetch stage (I-side) and the memory stage (D-side) of the pipelined processor.
- Sequences each access: grant, one-cycle issue, latency countdown, completion.
- Returns read data to the requester and drives per-requester stall signals into the pipeline.
- D-side has priority; a streak limit prevents fetch starvation.

Parameters:
WIDTH, 16, address/data width
LATENCY, 2, cycles from the mem_en cycle to the cycle mem_rdata is valid (legal range 1..15)
MAX_D_STREAK, 2, consecutive D grants allowed while i_req is pending before I is forced

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
i_req  in  1  fetch read request; held with stable i_addr until i_done
i_addr  in  WIDTH  fetch address
i_rdata  out  WIDTH  fetched instruction; registered, valid while i_done=1, held until next I completion
i_done  out  1  one-cycle completion pulse
i_stall  out  1  i_req & ~i_done
d_req  in  1  data request; held with stable d_wr/d_addr/d_wdata until d_done
d_wr  in  1  1 = write, 0 = read
d_addr  in  WIDTH  data address
d_wdata  in  WIDTH  store data
d_rdata  out  WIDTH  load data; registered; updated only on D reads
d_done  out  1  one-cycle completion pulse
d_stall  out  1  d_req & ~d_done
mem_en  out  1  registered one-cycle issue strobe
mem_wr  out  1  write qualifier, valid with mem_en
mem_addr  out  WIDTH  latched address, valid with mem_en
mem_wdata  out  WIDTH  latched write data, valid with mem_en
mem_rdata  in  WIDTH  memory read data, valid exactly LATENCY cycles after mem_en

Behaviour:
- Clocking/reset: one clock, clk. rst is synchronous and active-high.
- Reset: state IDLE, counter 0, streak 0. All outputs 0, including i_rdata and d_rdata.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE, cycle N:
  - Evaluate requests, excluding any port whose done is high this cycle.
  - Grant D if d_req, unless streak==MAX_D_STREAK and i_req; otherwise grant I if i_req.
  - On a grant: latch owner, wr, addr, wdata; go to ISSUE.
  - No grant: stay in IDLE.
- ISSUE, cycle N+1:
  - mem_en=1 with the latched mem_wr/mem_addr/mem_wdata.
  - Load counter=LATENCY; go to WAIT.
- WAIT:
  - Decrement the counter each cycle.
  - In cycle N+1+LATENCY (counter==1): capture mem_rdata into the owner's rdata register; a write leaves d_rdata unchanged. Go to DONE.
- DONE, cycle N+2+LATENCY:
  - Owner's done=1 for exactly one cycle.
  - Streak update: D grant → streak+1, saturating at MAX_D_STREAK. I grant → streak 0.
  - Same-cycle arbitration (IDLE-equivalent) runs here, excluding the owner. A pending other port is granted immediately (DONE→ISSUE). Otherwise the next state is IDLE.
- Throughput: at most one access per LATENCY+2 cycles. Access latency is LATENCY+2 cycles from grant cycle to done.
- mem_wr, mem_addr and mem_wdata are 0 outside the mem_en cycle.
- Streak is reset to 0 whenever i_req is low in a grant cycle.
- Requester dropping req before its done: the access still completes and done still pulses (protocol violation, not an error).
- Simultaneous i_req and d_req from IDLE with streak<MAX: D wins; I stalls.
- rst mid-access (any state): return to IDLE next cycle. No done pulse. Any in-flight mem_rdata is ignored.
- Widths: counter is 4 bits. No arithmetic is performed on data or addresses.

Decomposition:
- Shared package: WIDTH default, state encodings (IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2, DONE=2'd3), owner encoding (OWN_I=1'b0, OWN_D=1'b1).
- One sub-module, mem_arb_lat_counter: loadable 4-bit down-counter with sync reset and a last-cycle flag (count==1).
- Arbitration, streak and datapath latches stay in mem_arbiter.

Test Plan:
- I-only read, LATENCY=2, i_req at cycle 0, i_addr=16'h0010, mem model returns 16'hABCD → mem_en in cycle 1 with addr 16'h0010; i_done and i_rdata=16'hABCD in cycle 4; i_stall=1 in cycles 0-3.
- Simultaneous i_req and d_req (read, addr 16'h0200), streak=0 → D served first: mem_en cycle 1, d_done cycle 4. I is granted in cycle 4: mem_en cycle 5, i_done cycle 8.
- d_req held continuously across back-to-back stores, i_req held high → grant order D, D, I, D. Streak returns to 0 after the I grant.
- D write, d_addr=16'h0004, d_wdata=16'h1234, d_rdata previously 16'h5555 → mem_en=1, mem_wr=1, mem_addr=16'h0004, mem_wdata=16'h1234; d_done at +4; d_rdata remains 16'h5555.
- rst asserted in cycle 2 of an I access → no i_done; all outputs 0 in cycle 3. A new i_req issued after reset completes with fresh data.
- LATENCY=1 rebuild, I read → done exactly 3 cycles after the grant cycle; a requester holding req through its done cycle is not re-granted in that cycle.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the I/D memory-port arbiter.
package mem_arbiter_pkg;

  localparam int unsigned WIDTH_DEF = 16;
  localparam int unsigned CNT_W     = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } arbState_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and memory-port signals of the arbiter, bundled for port lists.
interface mem_arbiter_if
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) ();

  logic             i_req;
  logic [WIDTH-1:0] i_addr;
  logic [WIDTH-1:0] i_rdata;
  logic             i_done;
  logic             i_stall;

  logic             d_req;
  logic             d_wr;
  logic [WIDTH-1:0] d_addr;
  logic [WIDTH-1:0] d_wdata;
  logic [WIDTH-1:0] d_rdata;
  logic             d_done;
  logic             d_stall;

  logic             mem_en;
  logic             mem_wr;
  logic [WIDTH-1:0] mem_addr;
  logic [WIDTH-1:0] mem_wdata;
  logic [WIDTH-1:0] mem_rdata;

  // Arbiter side
  modport slave (
    input  i_req, i_addr, d_req, d_wr, d_addr, d_wdata, mem_rdata,
    output i_rdata, i_done, i_stall, d_rdata, d_done, d_stall,
           mem_en, mem_wr, mem_addr, mem_wdata
  );

  // Pipeline/memory side
  modport master (
    output i_req, i_addr, d_req, d_wr, d_addr, d_wdata, mem_rdata,
    input  i_rdata, i_done, i_stall, d_rdata, d_done, d_stall,
           mem_en, mem_wr, mem_addr, mem_wdata
  );

endinterface

// File: rtl/mem_arb_lat_counter.sv
// Loadable down-counter timing the memory latency; last is high while count==1.
module mem_arb_lat_counter
  import mem_arbiter_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] loadValue,
  input  logic             dec,
  output logic             last
);

  logic [CNT_W-1:0] count;

  // last is registered alongside count so it is valid in the same cycle as count==1
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      last  <= 1'b0;
    end else if (load) begin
      count <= loadValue;
      last  <= (loadValue == CNT_W'(1));
    end else if (dec && (count != '0)) begin
      count <= count - CNT_W'(1);
      last  <= (count == CNT_W'(2));
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one fixed-latency memory port between fetch (I) and memory-stage (D)
// requesters; D has priority, bounded by a streak limit while I waits.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH        = WIDTH_DEF,
  parameter int unsigned LATENCY      = 2,
  parameter int unsigned MAX_D_STREAK = 2
) (
  input  logic         clk,
  input  logic         rst,
  mem_arbiter_if.slave bus
);

  localparam logic [CNT_W-1:0] LAT_LOAD   = CNT_W'(LATENCY);
  localparam logic [CNT_W-1:0] STREAK_MAX = CNT_W'(MAX_D_STREAK);

  arbState_t        state, stateNxt;
  owner_t           owner, ownerNxt;
  logic             wrLat, wrLatNxt;
  logic [CNT_W-1:0] streak, streakNxt;
  logic             memEn, memEnNxt;
  logic             memWr, memWrNxt;
  logic [WIDTH-1:0] memAddr, memAddrNxt;
  logic [WIDTH-1:0] memWdata, memWdataNxt;
  logic [WIDTH-1:0] iRdata, iRdataNxt;
  logic [WIDTH-1:0] dRdata, dRdataNxt;
  logic             iDone, iDoneNxt;
  logic             dDone, dDoneNxt;
  logic             cntLoad, cntDec, cntLast;
  logic             eligI, eligD, grantI, grantD;

  mem_arb_lat_counter uLatCnt (
    .clk       (clk),
    .rst       (rst),
    .load      (cntLoad),
    .loadValue (LAT_LOAD),
    .dec       (cntDec),
    .last      (cntLast)
  );

  // A port whose done is pulsing this cycle is not eligible for a new grant
  assign eligI  = bus.i_req & ~iDone;
  assign eligD  = bus.d_req & ~dDone;
  assign grantD = eligD & ~((streak == STREAK_MAX) & eligI);
  assign grantI = eligI & ~grantD;

  always_comb begin
    stateNxt    = state;
    ownerNxt    = owner;
    wrLatNxt    = wrLat;
    streakNxt   = streak;
    memEnNxt    = 1'b0;
    memWrNxt    = 1'b0;
    memAddrNxt  = '0;
    memWdataNxt = '0;
    iRdataNxt   = iRdata;
    dRdataNxt   = dRdata;
    iDoneNxt    = 1'b0;
    dDoneNxt    = 1'b0;
    cntLoad     = 1'b0;
    cntDec      = 1'b0;

    case (state)
      IDLE, DONE: begin
        if (state == DONE) begin
          if (owner == OWN_D) begin
            if (streak != STREAK_MAX) streakNxt = streak + CNT_W'(1);
          end else begin
            streakNxt = '0;
          end
        end
        // DONE arbitrates like IDLE so the other port can follow without a gap
        if (grantD || grantI) begin
          stateNxt    = ISSUE;
          ownerNxt    = grantD ? OWN_D : OWN_I;
          wrLatNxt    = grantD & bus.d_wr;
          memEnNxt    = 1'b1;
          memWrNxt    = grantD & bus.d_wr;
          memAddrNxt  = grantD ? bus.d_addr : bus.i_addr;
          memWdataNxt = grantD ? bus.d_wdata : '0;
          if (!bus.i_req) streakNxt = '0;
        end else begin
          stateNxt = IDLE;
        end
      end
      ISSUE: begin
        cntLoad  = 1'b1;
        stateNxt = WAIT;
      end
      WAIT: begin
        cntDec = 1'b1;
        if (cntLast) begin
          stateNxt = DONE;
          if (owner == OWN_D) begin
            dDoneNxt = 1'b1;
            if (!wrLat) dRdataNxt = bus.mem_rdata;
          end else begin
            iDoneNxt  = 1'b1;
            iRdataNxt = bus.mem_rdata;
          end
        end
      end
      default: stateNxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      owner    <= OWN_I;
      wrLat    <= 1'b0;
      streak   <= '0;
      memEn    <= 1'b0;
      memWr    <= 1'b0;
      memAddr  <= '0;
      memWdata <= '0;
      iRdata   <= '0;
      dRdata   <= '0;
      iDone    <= 1'b0;
      dDone    <= 1'b0;
    end else begin
      state    <= stateNxt;
      owner    <= ownerNxt;
      wrLat    <= wrLatNxt;
      streak   <= streakNxt;
      memEn    <= memEnNxt;
      memWr    <= memWrNxt;
      memAddr  <= memAddrNxt;
      memWdata <= memWdataNxt;
      iRdata   <= iRdataNxt;
      dRdata   <= dRdataNxt;
      iDone    <= iDoneNxt;
      dDone    <= dDoneNxt;
    end
  end

  assign bus.mem_en    = memEn;
  assign bus.mem_wr    = memWr;
  assign bus.mem_addr  = memAddr;
  assign bus.mem_wdata = memWdata;
  assign bus.i_rdata   = iRdata;
  assign bus.d_rdata   = dRdata;
  assign bus.i_done    = iDone;
  assign bus.d_done    = dDone;
  assign bus.i_stall   = bus.i_req & ~iDone;
  assign bus.d_stall   = bus.d_req & ~dDone;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: LATENCY=2 instance plus a LATENCY=1 rebuild.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst2;
  logic rst1;
  int   cyc = 0;
  int   passCnt = 0;
  int   totalCnt = 0;

  mem_arbiter_if #(.WIDTH(16)) bus2 ();
  mem_arbiter_if #(.WIDTH(16)) bus1 ();

  mem_arbiter #(.WIDTH(16), .LATENCY(2), .MAX_D_STREAK(2)) dut2 (
    .clk (clk),
    .rst (rst2),
    .bus (bus2)
  );

  mem_arbiter #(.WIDTH(16), .LATENCY(1), .MAX_D_STREAK(2)) dut1 (
    .clk (clk),
    .rst (rst1),
    .bus (bus1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] romData(input logic [15:0] a);
    case (a)
      16'h0010: romData = 16'hABCD;
      16'h0200: romData = 16'h0F0F;
      16'h0040: romData = 16'h4444;
      16'h0030: romData = 16'h3030;
      16'h0032: romData = 16'h3232;
      16'h0050: romData = 16'h5555;
      16'h0060: romData = 16'h6060;
      16'h0070: romData = 16'h7070;
      default:  romData = ~a;
    endcase
  endfunction

  // Memory models: read data is valid only in the cycle exactly LATENCY after mem_en
  logic        pend2 = 1'b0;
  logic        pend1 = 1'b0;
  int          due2 = 0;
  int          due1 = 0;
  logic [15:0] addr2 = '0;
  logic [15:0] addr1 = '0;

  always @(negedge clk) begin
    if (pend2 && due2 == cyc) begin
      bus2.mem_rdata = romData(addr2);
      pend2 = 1'b0;
    end else begin
      bus2.mem_rdata = 16'hDEAD;
    end
    if (bus2.mem_en && !bus2.mem_wr) begin
      pend2 = 1'b1;
      due2  = cyc + 2;
      addr2 = bus2.mem_addr;
    end
  end

  always @(negedge clk) begin
    if (pend1 && due1 == cyc) begin
      bus1.mem_rdata = romData(addr1);
      pend1 = 1'b0;
    end else begin
      bus1.mem_rdata = 16'hDEAD;
    end
    if (bus1.mem_en && !bus1.mem_wr) begin
      pend1 = 1'b1;
      due1  = cyc + 1;
      addr1 = bus1.mem_addr;
    end
  end

  task automatic test_reset();
    rst2 = 1'b1; rst1 = 1'b1;
    bus2.i_req = 1'b0; bus2.i_addr = '0; bus2.d_req = 1'b0; bus2.d_wr = 1'b0;
    bus2.d_addr = '0; bus2.d_wdata = '0;
    bus1.i_req = 1'b0; bus1.i_addr = '0; bus1.d_req = 1'b0; bus1.d_wr = 1'b0;
    bus1.d_addr = '0; bus1.d_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    rst2 = 1'b0; rst1 = 1'b0;
    @(negedge clk);
    totalCnt++;
    if ({bus2.mem_en, bus2.mem_wr, bus2.mem_addr, bus2.mem_wdata} !== 34'd0)
      $display("FAIL reset_mem2 got=%h exp=0", {bus2.mem_en, bus2.mem_wr, bus2.mem_addr, bus2.mem_wdata});
    else passCnt++;
    totalCnt++;
    if ({bus2.i_rdata, bus2.i_done, bus2.i_stall, bus2.d_rdata, bus2.d_done, bus2.d_stall} !== 36'd0)
      $display("FAIL reset_req2 got=%h exp=0", {bus2.i_rdata, bus2.i_done, bus2.i_stall, bus2.d_rdata, bus2.d_done, bus2.d_stall});
    else passCnt++;
    totalCnt++;
    if ({bus1.mem_en, bus1.mem_addr, bus1.i_rdata, bus1.i_done, bus1.d_rdata, bus1.d_done} !== 51'd0)
      $display("FAIL reset_dut1 got=%h exp=0", {bus1.mem_en, bus1.mem_addr, bus1.i_rdata, bus1.i_done, bus1.d_rdata, bus1.d_done});
    else passCnt++;
    @(posedge clk); #1;
  endtask

  task automatic test_i_read();
    for (int c = 0; c <= 5; c++) begin
      if (c == 0) begin bus2.i_req = 1'b1; bus2.i_addr = 16'h0010; end
      if (c == 5) bus2.i_req = 1'b0;
      @(negedge clk);
      totalCnt++;
      if (bus2.mem_en !== (c == 1)) $display("FAIL iread_mem_en c=%0d got=%b exp=%b", c, bus2.mem_en, (c == 1));
      else passCnt++;
      totalCnt++;
      if (bus2.i_done !== (c == 4)) $display("FAIL iread_i_done c=%0d got=%b exp=%b", c, bus2.i_done, (c == 4));
      else passCnt++;
      totalCnt++;
      if (bus2.i_stall !== (c <= 3)) $display("FAIL iread_i_stall c=%0d got=%b exp=%b", c, bus2.i_stall, (c <= 3));
      else passCnt++;
      if (c == 1) begin
        totalCnt++;
        if (bus2.mem_addr !== 16'h0010 || bus2.mem_wr !== 1'b0)
          $display("FAIL iread_issue got addr=%h wr=%b exp addr=0010 wr=0", bus2.mem_addr, bus2.mem_wr);
        else passCnt++;
      end
      if (c == 4) begin
        totalCnt++;
        if (bus2.i_rdata !== 16'hABCD) $display("FAIL iread_rdata got=%h exp=abcd", bus2.i_rdata);
        else passCnt++;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_priority();
    for (int c = 0; c <= 9; c++) begin
      if (c == 0) begin
        bus2.i_req = 1'b1; bus2.i_addr = 16'h0040;
        bus2.d_req = 1'b1; bus2.d_wr = 1'b0; bus2.d_addr = 16'h0200;
      end
      if (c == 5) bus2.d_req = 1'b0;
      if (c == 9) bus2.i_req = 1'b0;
      @(negedge clk);
      totalCnt++;
      if (bus2.mem_en !== (c == 1 || c == 5)) $display("FAIL prio_mem_en c=%0d got=%b", c, bus2.mem_en);
      else passCnt++;
      totalCnt++;
      if ({bus2.d_done, bus2.i_done} !== {(c == 4), (c == 8)})
        $display("FAIL prio_done c=%0d got d=%b i=%b", c, bus2.d_done, bus2.i_done);
      else passCnt++;
      totalCnt++;
      if ({bus2.d_stall, bus2.i_stall} !== {(c <= 3), (c <= 7)})
        $display("FAIL prio_stall c=%0d got d=%b i=%b", c, bus2.d_stall, bus2.i_stall);
      else passCnt++;
      if (c == 1 || c == 5) begin
        totalCnt++;
        if (bus2.mem_addr !== ((c == 1) ? 16'h0200 : 16'h0040))
          $display("FAIL prio_addr c=%0d got=%h exp=%h", c, bus2.mem_addr, ((c == 1) ? 16'h0200 : 16'h0040));
        else passCnt++;
      end
      if (c == 4) begin
        totalCnt++;
        if (bus2.d_rdata !== 16'h0F0F) $display("FAIL prio_d_rdata got=%h exp=0f0f", bus2.d_rdata);
        else passCnt++;
      end
      if (c == 8) begin
        totalCnt++;
        if (bus2.i_rdata !== 16'h4444) $display("FAIL prio_i_rdata got=%h exp=4444", bus2.i_rdata);
        else passCnt++;
      end
      @(posedge clk); #1;
    end
  endtask

  // Grant order D, D, I, D, then D, I again (streak restarts from 0 after the I grant)
  task automatic test_back_to_back();
    logic        expEn, expWr;
    logic [15:0] expAddr, expWdata;
    for (int c = 0; c <= 27; c++) begin
      case (c)
        0:  begin bus2.d_req = 1'b1; bus2.d_wr = 1'b1; bus2.d_addr = 16'h0020; bus2.d_wdata = 16'h1111; end
        5:  begin bus2.d_addr = 16'h0022; bus2.d_wdata = 16'h2222; bus2.i_req = 1'b1; bus2.i_addr = 16'h0030; end
        10: begin bus2.d_addr = 16'h0024; bus2.d_wdata = 16'h3333; end
        14: bus2.i_req = 1'b0;
        18: begin bus2.d_addr = 16'h0026; bus2.d_wdata = 16'h4444; bus2.i_req = 1'b1; bus2.i_addr = 16'h0032; end
        23: bus2.d_req = 1'b0;
        27: bus2.i_req = 1'b0;
        default: ;
      endcase
      expEn = 1'b1;
      case (c)
        1:  begin expAddr = 16'h0020; expWr = 1'b1; expWdata = 16'h1111; end
        6:  begin expAddr = 16'h0022; expWr = 1'b1; expWdata = 16'h2222; end
        10: begin expAddr = 16'h0030; expWr = 1'b0; expWdata = 16'h0000; end
        14: begin expAddr = 16'h0024; expWr = 1'b1; expWdata = 16'h3333; end
        19: begin expAddr = 16'h0026; expWr = 1'b1; expWdata = 16'h4444; end
        23: begin expAddr = 16'h0032; expWr = 1'b0; expWdata = 16'h0000; end
        default: begin expEn = 1'b0; expAddr = '0; expWr = 1'b0; expWdata = '0; end
      endcase
      @(negedge clk);
      totalCnt++;
      if ({bus2.mem_en, bus2.mem_wr, bus2.mem_addr} !== {expEn, expWr, expAddr})
        $display("FAIL b2b_issue c=%0d got en=%b wr=%b addr=%h exp en=%b wr=%b addr=%h",
                 c, bus2.mem_en, bus2.mem_wr, bus2.mem_addr, expEn, expWr, expAddr);
      else passCnt++;
      totalCnt++;
      if (bus2.mem_wdata !== expWdata) $display("FAIL b2b_wdata c=%0d got=%h exp=%h", c, bus2.mem_wdata, expWdata);
      else passCnt++;
      totalCnt++;
      if ({bus2.d_done, bus2.i_done} !== {(c == 4 || c == 9 || c == 17 || c == 22), (c == 13 || c == 26)})
        $display("FAIL b2b_done c=%0d got d=%b i=%b", c, bus2.d_done, bus2.i_done);
      else passCnt++;
      if (c == 13 || c == 26) begin
        totalCnt++;
        if (bus2.i_rdata !== ((c == 13) ? 16'h3030 : 16'h3232))
          $display("FAIL b2b_i_rdata c=%0d got=%h exp=%h", c, bus2.i_rdata, ((c == 13) ? 16'h3030 : 16'h3232));
        else passCnt++;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_d_write();
    bit seen = 1'b0;
    bus2.d_req = 1'b1; bus2.d_wr = 1'b0; bus2.d_addr = 16'h0050;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (bus2.d_done) seen = 1'b1;
      @(posedge clk); #1;
    end
    bus2.d_req = 1'b0;
    totalCnt++;
    if (!seen || bus2.d_rdata !== 16'h5555) $display("FAIL wr_preload seen=%b got=%h exp=5555", seen, bus2.d_rdata);
    else passCnt++;
    @(posedge clk); #1;
    for (int c = 0; c <= 5; c++) begin
      if (c == 0) begin bus2.d_req = 1'b1; bus2.d_wr = 1'b1; bus2.d_addr = 16'h0004; bus2.d_wdata = 16'h1234; end
      if (c == 5) bus2.d_req = 1'b0;
      @(negedge clk);
      totalCnt++;
      if (bus2.mem_en !== (c == 1)) $display("FAIL wr_mem_en c=%0d got=%b exp=%b", c, bus2.mem_en, (c == 1));
      else passCnt++;
      totalCnt++;
      if (bus2.d_done !== (c == 4)) $display("FAIL wr_d_done c=%0d got=%b exp=%b", c, bus2.d_done, (c == 4));
      else passCnt++;
      if (c == 1) begin
        totalCnt++;
        if ({bus2.mem_wr, bus2.mem_addr, bus2.mem_wdata} !== {1'b1, 16'h0004, 16'h1234})
          $display("FAIL wr_issue got wr=%b addr=%h wdata=%h exp wr=1 addr=0004 wdata=1234",
                   bus2.mem_wr, bus2.mem_addr, bus2.mem_wdata);
        else passCnt++;
      end
      if (c >= 4) begin
        totalCnt++;
        if (bus2.d_rdata !== 16'h5555) $display("FAIL wr_d_rdata c=%0d got=%h exp=5555", c, bus2.d_rdata);
        else passCnt++;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid();
    for (int c = 0; c <= 11; c++) begin
      case (c)
        0: begin bus2.i_req = 1'b1; bus2.i_addr = 16'h0060; end
        2: begin rst2 = 1'b1; bus2.i_req = 1'b0; end
        3: rst2 = 1'b0;
        7: begin bus2.i_req = 1'b1; bus2.i_addr = 16'h0070; end
        default: ;
      endcase
      @(negedge clk);
      if (c == 3) begin
        totalCnt++;
        if ({bus2.mem_en, bus2.mem_wr, bus2.mem_addr, bus2.mem_wdata, bus2.i_rdata, bus2.i_done,
             bus2.i_stall, bus2.d_rdata, bus2.d_done, bus2.d_stall} !== 70'd0)
          $display("FAIL rstmid_outputs got=%h exp=0", {bus2.mem_en, bus2.mem_wr, bus2.mem_addr, bus2.mem_wdata,
                   bus2.i_rdata, bus2.i_done, bus2.i_stall, bus2.d_rdata, bus2.d_done, bus2.d_stall});
        else passCnt++;
      end
      if (c >= 3) begin
        totalCnt++;
        if (bus2.i_done !== (c == 11)) $display("FAIL rstmid_i_done c=%0d got=%b exp=%b", c, bus2.i_done, (c == 11));
        else passCnt++;
        totalCnt++;
        if (bus2.mem_en !== (c == 8)) $display("FAIL rstmid_mem_en c=%0d got=%b exp=%b", c, bus2.mem_en, (c == 8));
        else passCnt++;
      end
      if (c == 11) begin
        totalCnt++;
        if (bus2.i_rdata !== 16'h7070) $display("FAIL rstmid_rdata got=%h exp=7070", bus2.i_rdata);
        else passCnt++;
      end
      @(posedge clk); #1;
    end
    bus2.i_req = 1'b0;
  endtask

  task automatic test_latency1();
    for (int c = 0; c <= 8; c++) begin
      case (c)
        0: begin bus1.i_req = 1'b1; bus1.i_addr = 16'h0010; end
        4: bus1.i_addr = 16'h0040;
        8: bus1.i_req = 1'b0;
        default: ;
      endcase
      @(negedge clk);
      totalCnt++;
      if (bus1.mem_en !== (c == 1 || c == 5)) $display("FAIL lat1_mem_en c=%0d got=%b", c, bus1.mem_en);
      else passCnt++;
      totalCnt++;
      if (bus1.i_done !== (c == 3 || c == 7)) $display("FAIL lat1_i_done c=%0d got=%b", c, bus1.i_done);
      else passCnt++;
      totalCnt++;
      if (bus1.i_stall !== (c != 3 && c != 7 && c < 8)) $display("FAIL lat1_i_stall c=%0d got=%b", c, bus1.i_stall);
      else passCnt++;
      if (c == 5) begin
        totalCnt++;
        if (bus1.mem_addr !== 16'h0040) $display("FAIL lat1_addr got=%h exp=0040", bus1.mem_addr);
        else passCnt++;
      end
      if (c == 3 || c == 7) begin
        totalCnt++;
        if (bus1.i_rdata !== ((c == 3) ? 16'hABCD : 16'h4444))
          $display("FAIL lat1_rdata c=%0d got=%h exp=%h", c, bus1.i_rdata, ((c == 3) ? 16'hABCD : 16'h4444));
        else passCnt++;
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_i_read();
    test_priority();
    test_back_to_back();
    test_d_write();
    test_reset_mid();
    test_latency1();
    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
